// File: rtl/memory_stage_pkg.sv
// Shared encodings for the memory stage: funct3 load/store widths, ResultSrc selects, FSM states.
package memory_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_MEM = 2'b01;
    localparam logic [1:0] RS_PC4 = 2'b10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/memory_stage_load_extend.sv
// load_extend: selects the addressed byte/half lane of a read word and sign/zero-extends it.
module load_extend
    import memory_stage_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic [D_WIDTH-1:0] rdata,
    input  logic [2:0]         funct3,
    input  logic [1:0]         offset,
    output logic [D_WIDTH-1:0] data
);

    logic [4:0]  byte_pos;
    logic [4:0]  half_pos;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Half lane uses only offset[1]; an odd half offset is ignored rather than straddling lanes.
    assign byte_pos = {offset, 3'b000};
    assign half_pos = {offset[1], 4'b0000};
    assign lane_b   = rdata[byte_pos +: 8];
    assign lane_h   = rdata[half_pos +: 16];

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{(D_WIDTH-8){lane_b[7]}}, lane_b};
            F3_H:    data = {{(D_WIDTH-16){lane_h[15]}}, lane_h};
            F3_BU:   data = {{(D_WIDTH-8){1'b0}}, lane_b};
            F3_HU:   data = {{(D_WIDTH-16){1'b0}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: issues loads/stores to data memory, stalls on wait states, feeds the M/W register.
// Optional MEM_MISALIGN_CHECK_EN traps misaligned half/word accesses instead of issuing them.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RegWriteM,
    input  logic [1:0]         ResultSrcM,
    input  logic               MemWriteM,
    input  logic [2:0]         funct3M,
    input  logic [D_WIDTH-1:0] ALUResultM,
    input  logic [D_WIDTH-1:0] WriteDataM,
    input  logic [A_WIDTH-1:0] RdM,
    input  logic [D_WIDTH-1:0] PCPlus4M,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [D_WIDTH-1:0] dmem_addr,
    output logic [D_WIDTH-1:0] dmem_wdata,
    output logic [3:0]         dmem_be,
    input  logic [D_WIDTH-1:0] dmem_rdata,
    input  logic               dmem_ack,
    output logic               RegWriteW,
    output logic [1:0]         ResultSrcW,
    output logic [D_WIDTH-1:0] ReadDataW,
    output logic [D_WIDTH-1:0] ALUResultW,
    output logic [A_WIDTH-1:0] RdW,
    output logic [D_WIDTH-1:0] PCPlus4W,
    output logic               StallM,
    output logic               MisalignM
);

    mem_state_t         state;
    logic               is_load;
    logic               mem_op;
    logic               misalign;
    logic [D_WIDTH-1:0] load_data;

    assign is_load = (ResultSrcM == RS_MEM);
    assign mem_op  = is_load | MemWriteM;

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        if (mem_op) begin
            case (funct3M)
                F3_H:    misalign = ALUResultM[0];
                F3_HU:   misalign = is_load & ALUResultM[0];
                F3_W:    misalign = |ALUResultM[1:0];
                default: misalign = 1'b0;
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    // Gating with rst drops the request in the very cycle reset hits, even mid-access.
    assign dmem_req  = !rst && (((state == S_IDLE) && mem_op && !misalign) || (state == S_WAIT));
    assign StallM    = dmem_req && !dmem_ack;
    assign MisalignM = !rst && (state == S_IDLE) && misalign;
    assign dmem_we   = MemWriteM;
    assign dmem_addr = {ALUResultM[D_WIDTH-1:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b0000;
        dmem_wdata = WriteDataM;
        if (MemWriteM) begin
            case (funct3M)
                F3_B: begin
                    dmem_be    = 4'b0001 << ALUResultM[1:0];
                    dmem_wdata = D_WIDTH'({4{WriteDataM[7:0]}});
                end
                F3_H: begin
                    dmem_be    = 4'b0011 << {ALUResultM[1], 1'b0};
                    dmem_wdata = D_WIDTH'({2{WriteDataM[15:0]}});
                end
                F3_W:    dmem_be = 4'b1111;
                default: dmem_be = 4'b0000;
            endcase
        end
    end

    load_extend #(.D_WIDTH(D_WIDTH)) u_load_extend (
        .rdata  (dmem_rdata),
        .funct3 (funct3M),
        .offset (ALUResultM[1:0]),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (mem_op && !misalign && !dmem_ack) state <= S_WAIT;
                S_WAIT: if (dmem_ack) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            ReadDataW  <= '0;
            ALUResultW <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
        end else if (StallM || MisalignM) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            ReadDataW  <= '0;
            ALUResultW <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
        end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            ReadDataW  <= is_load ? load_data : '0;
            ALUResultW <= ALUResultM;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized traffic against a model.
`timescale 1ns/1ps
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        RegWriteW, StallM, MisalignM;
    logic [1:0]  ResultSrcW;
    logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
    logic [4:0]  RdW;

    memory_stage #(.D_WIDTH(32), .A_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ReadDataW(ReadDataW),
        .ALUResultW(ALUResultW), .RdW(RdW), .PCPlus4W(PCPlus4W),
        .StallM(StallM), .MisalignM(MisalignM)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] rd,
                                               input logic [31:0] addr);
        logic [31:0] b, h;
        b = (rd >> (8 * (addr % 4))) & 32'hFF;
        h = (rd >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic model_mis(input logic mem, input logic load, input logic [2:0] f3,
                                       input logic [31:0] addr);
`ifdef MEM_MISALIGN_CHECK_EN
        if (!mem) return 1'b0;
        if (f3 == 3'd1 || (f3 == 3'd5 && load)) return (addr % 2) != 0;
        if (f3 == 3'd2) return (addr % 4) != 0;
        return 1'b0;
`else
        return 1'b0 & mem & load & f3[0] & addr[0];
`endif
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'd0:    return 4'(1 << (addr % 4));
            3'd1:    return 4'(3 << (2 * ((addr / 2) % 2)));
            3'd2:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'd0:    return (wd & 32'hFF) * 32'h0101_0101;
            3'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    // Expected W contents, derived one cycle ahead from the current M inputs.
    logic        e_rw, have_exp = 1'b0;
    logic [1:0]  e_rs;
    logic [31:0] e_rdata, e_alu, e_pc;
    logic [4:0]  e_rd;
    logic        m_load, m_mem, m_mis, m_req, m_stall;

    always @(negedge clk) begin
        if (chk_on) begin
            if (rst) begin
                chk("w_regwrite_rst", RegWriteW, 0);
                chk("w_resultsrc_rst", ResultSrcW, 0);
                chk("w_readdata_rst", ReadDataW, 0);
                chk("w_alu_rst", ALUResultW, 0);
                chk("w_rd_rst", RdW, 0);
                chk("w_pc4_rst", PCPlus4W, 0);
            end else if (have_exp) begin
                chk("w_regwrite", RegWriteW, e_rw);
                chk("w_resultsrc", ResultSrcW, e_rs);
                chk("w_readdata", ReadDataW, e_rdata);
                chk("w_alu", ALUResultW, e_alu);
                chk("w_rd", RdW, e_rd);
                chk("w_pc4", PCPlus4W, e_pc);
            end
            m_load  = (ResultSrcM == 2'b01);
            m_mem   = m_load || MemWriteM;
            m_mis   = !rst && model_mis(m_mem, m_load, funct3M, ALUResultM);
            m_req   = !rst && m_mem && !m_mis;
            m_stall = m_req && !dmem_ack;
            chk("dmem_req", dmem_req, m_req);
            chk("stall", StallM, m_stall);
            chk("misalign", MisalignM, m_mis);
            if (m_req) begin
                chk("dmem_addr", dmem_addr, ALUResultM & 32'hFFFF_FFFC);
                chk("dmem_we", dmem_we, MemWriteM);
                if (MemWriteM) begin
                    chk("dmem_be", dmem_be, model_be(funct3M, ALUResultM));
                    if (model_be(funct3M, ALUResultM) != 0)
                        chk("dmem_wdata", dmem_wdata, model_wdata(funct3M, WriteDataM));
                end
            end
            if (rst || m_stall || m_mis) begin
                e_rw = 0; e_rs = 0; e_rdata = 0; e_alu = 0; e_rd = 0; e_pc = 0;
            end else begin
                e_rw    = RegWriteM;
                e_rs    = ResultSrcM;
                e_rdata = m_load ? model_load(funct3M, dmem_rdata, ALUResultM) : 32'h0;
                e_alu   = ALUResultM;
                e_rd    = RdM;
                e_pc    = PCPlus4M;
            end
            have_exp = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_m(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                           input logic [31:0] pc);
        RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; funct3M = f3;
        ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc;
    endtask

    task automatic nop();
        drive_m(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_random();
        int unsigned kind, waits, c;
        logic [1:0] rs;
        logic mw, mem, st;
        kind  = $urandom_range(0, 3);
        waits = $urandom_range(0, 3);
        rs = (kind == 1) ? 2'b01 : (kind == 3) ? 2'(2 + $urandom_range(0, 1)) : 2'b00;
        mw = (kind == 2);
        drive_m(1'($urandom_range(0, 1)), rs, mw, 3'($urandom_range(0, 7)), $urandom, $urandom,
                5'($urandom_range(0, 31)), $urandom);
        mem = (rs == 2'b01) || mw;
        c = 0;
        forever begin
            dmem_ack   = mem ? (c >= waits) : 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
            @(negedge clk);
            st = StallM;
            next_cycle();
            if (!st) break;
            c++;
            if (c > 10) begin
                checks++;
                failures++;
                $display("FAIL stall_bound: got %0d stall cycles expected at most %0d", c, waits);
                break;
            end
        end
    endtask

    initial begin
        nop();
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_regwrite", RegWriteW, 0);
        chk("reset_req", dmem_req, 0);
        next_cycle();
        rst = 1'b0;

        // LW zero-wait
        drive_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 32'h44);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lw_stall", StallM, 0);
        chk("lw_addr", dmem_addr, 32'h100);
        next_cycle();
        nop(); dmem_ack = 1'b0;
        @(negedge clk);
        chk("lw_data", ReadDataW, 32'hDEAD_BEEF);
        chk("lw_regwrite", RegWriteW, 1);

        // LB / LBU at 0x103 with two wait states
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            drive_m(1'b1, 2'b01, 1'b0, (k == 0) ? 3'b000 : 3'b100, 32'h103, 32'h0, 5'd9, 32'h50);
            dmem_ack = 1'b0; dmem_rdata = 32'h80FF_FF7F;
            @(negedge clk);
            chk("lb_stall0", StallM, 1);
            next_cycle();
            @(negedge clk);
            chk("lb_stall1", StallM, 1);
            chk("lb_bubble1", RegWriteW, 0);
            next_cycle();
            dmem_ack = 1'b1;
            @(negedge clk);
            chk("lb_ackcycle", StallM, 0);
            chk("lb_bubble2", RegWriteW, 0);
            next_cycle();
            nop(); dmem_ack = 1'b0;
            @(negedge clk);
            chk("lb_data", ReadDataW, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            chk("lb_regwrite", RegWriteW, 1);
        end

        // SH at 0x202
        next_cycle();
        drive_m(1'b0, 2'b00, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd0, 32'h0);
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_addr", dmem_addr, 32'h200);

        // reset while waiting, late ack ignored
        next_cycle();
        drive_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h300, 32'h0, 5'd3, 32'h60);
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("rstwait_stall", StallM, 1);
        next_cycle();
        rst = 1'b1;
        #1;
        chk("rstwait_req", dmem_req, 0);
        chk("rstwait_w", RegWriteW, 0);
        nop();
        next_cycle();
        rst = 1'b0; dmem_ack = 1'b1;
        @(negedge clk);
        chk("lateack_req", dmem_req, 0);
        chk("lateack_w", RegWriteW, 0);
        next_cycle();
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("lateack_w2", RegWriteW, 0);

        // LW at 0x101
        next_cycle();
        drive_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h101, 32'h0, 5'd4, 32'h70);
        dmem_ack = 1'b1; dmem_rdata = 32'h1122_3344;
        @(negedge clk);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("mis_req", dmem_req, 0);
        chk("mis_flag", MisalignM, 1);
`else
        chk("mis_addr", dmem_addr, 32'h100);
        chk("mis_flag", MisalignM, 0);
`endif
        next_cycle();
        nop(); dmem_ack = 1'b0;
        @(negedge clk);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("mis_wb", RegWriteW, 0);
        chk("mis_flag_off", MisalignM, 0);
`else
        chk("mis_wb", ReadDataW, 32'h1122_3344);
`endif

        // ALU op with no ack
        next_cycle();
        drive_m(1'b1, 2'b00, 1'b0, 3'b000, 32'hCAFE_0001, 32'h0, 5'd7, 32'h80);
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("alu_stall", StallM, 0);
        next_cycle();
        nop(); dmem_ack = 1'b1;
        @(negedge clk);
        chk("alu_result", ALUResultW, 32'hCAFE_0001);
        chk("alu_regwrite", RegWriteW, 1);
        chk("idle_ack_req", dmem_req, 0);
        next_cycle();

        repeat (400) issue_random();
        nop();
        dmem_ack = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
